wb_arbiter: RTL

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 27 ++
 rtl/wb_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if -- writeback request bundle for the two requesters.
//   A (ALU writeback):            a_valid, a_ready, a_addr[4:0], a_data[31:0]
//   B (load/multi-cycle writeback): b_valid, b_ready, b_addr[4:0], b_data[31:0]
// The master modport is the requester side (drives valid/addr/data), the
// slave modport is the arbiter side (drives ready).
interface wb_arbiter_if;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter -- two-requester round-robin writeback arbiter with a register
// busy scoreboard.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req (slave modport)   : requester A/B valid/ready/addr/data handshakes
//   wr_en/wr_addr/wr_data : registered register-file write port (1-cycle latency)
//   iss_valid/iss_addr    : issue notification, marks iss_addr as pending
//   rd1_addr/rd2_addr     : read indices under hazard check
//   rd1_busy/rd2_busy     : indexed register has a pending or in-flight write
//   idle                  : no pending writes and no write in flight
module wb_arbiter (
    input  logic               clk,
    input  logic               rst_n,
    wb_arbiter_if.slave        req,
    output logic               wr_en,
    output logic [4:0]         wr_addr,
    output logic [31:0]        wr_data,
    input  logic               iss_valid,
    input  logic [4:0]         iss_addr,
    input  logic [4:0]         rd1_addr,
    input  logic [4:0]         rd2_addr,
    output logic               rd1_busy,
    output logic               rd2_busy,
    output logic               idle
);

    // last_b = 1 means B was granted most recently, so A wins the next tie.
    logic        last_b;
    // Bit 0 is kept permanently clear so r0 can be indexed like any other.
    logic [31:0] busy;
    logic [31:0] busy_next;

    logic        xfer_a;
    logic        xfer_b;
    logic        xfer;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;

    // Grant: a lone requester always wins; on a tie the one not granted last.
    // Gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        req.a_ready = rst_n & req.a_valid & (~req.b_valid | last_b);
        req.b_ready = rst_n & req.b_valid & (~req.a_valid | ~last_b);
    end

    assign xfer_a    = req.a_valid & req.a_ready;
    assign xfer_b    = req.b_valid & req.b_ready;
    assign xfer      = xfer_a | xfer_b;
    assign xfer_addr = xfer_a ? req.a_addr : req.b_addr;
    assign xfer_data = xfer_a ? req.a_data : req.b_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (xfer) begin
            last_b <= xfer_b;
        end
    end

    // Write port: a transfer to r0 still updates addr/data but never enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= 5'd0;
            wr_data <= 32'd0;
        end else begin
            wr_en <= xfer && (xfer_addr != 5'd0);
            if (xfer) begin
                wr_addr <= xfer_addr;
                wr_data <= xfer_data;
            end
        end
    end

    // Clear on writeback first, then set on issue so a same-cycle issue wins.
    always_comb begin
        busy_next = busy;
        if (xfer && (xfer_addr != 5'd0)) begin
            busy_next[xfer_addr] = 1'b0;
        end
        if (iss_valid && (iss_addr != 5'd0)) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 32'd0;
        end else begin
            busy <= busy_next;
        end
    end

    // A register stays busy through the cycle its write is on the port.
    always_comb begin
        rd1_busy = (rd1_addr != 5'd0) &&
                   (busy[rd1_addr] || (wr_en && (wr_addr == rd1_addr)));
        rd2_busy = (rd2_addr != 5'd0) &&
                   (busy[rd2_addr] || (wr_en && (wr_addr == rd2_addr)));
        idle     = (busy == 32'd0) && !wr_en;
    end

endmodule
